// File: rtl/gray_pkg.sv
// Shared Gray-code helpers and constants for the up/down Gray counter family.
// Functions work on 32-bit containers; callers cast to their own WIDTH.
package gray_pkg;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b[31] = g[31];
        for (int i = 30; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // Gray image of the all-ones binary count: MSB set, everything else clear.
    function automatic logic [31:0] GRAY_MAX(input int w);
        return 32'd1 << (w - 1);
    endfunction

endpackage

// File: rtl/gray_ud_next.sv
// Combinational single-step successor of a Gray value in either direction,
// using the binary LSB (parity) instead of a full Gray-to-binary conversion.
module gray_ud_next
    import gray_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] i_gray,
    input  logic             i_parity,
    input  logic             i_dir,
    output logic [WIDTH-1:0] o_next,
    output logic             o_at_limit
);

    localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(GRAY_MAX(WIDTH));
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

    logic [WIDTH-1:0] w_low;
    logic [WIDTH-1:0] w_left;
    logic [WIDTH-1:0] w_flip;

    always_comb begin
        w_low  = i_gray & (~i_gray + ONE);
        w_left = w_low << 1;
        // Lowest set bit at the MSB (or no bit set at all) folds onto the MSB.
        if (w_left == '0) begin
            w_left = MSB_MASK;
        end
        w_flip     = ONE;
        o_at_limit = 1'b0;
        if (i_dir == DIR_UP) begin
            w_flip     = i_parity ? w_left : ONE;
            o_at_limit = i_parity && (i_gray == MSB_MASK);
        end else begin
            w_flip     = i_parity ? ONE : w_left;
            o_at_limit = (i_gray == '0);
        end
        o_next = i_gray ^ w_flip;
    end

endmodule

// File: rtl/gray_updown_counter.sv
// Up/down Gray counter with synchronous load, wrap or saturate mode and
// registered binary view, terminal-count flags and wrap pulse.
module gray_updown_counter
    import gray_pkg::*;
#(
    parameter int          WIDTH       = 16,
    parameter bit          SATURATE    = 1'b0,
    parameter logic [31:0] RESET_VALUE = 32'd0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             CE,
    input  logic             UP_N_DN,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] LOAD_VALUE,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Q_BIN,
    output logic             TC_MAX,
    output logic             TC_ZERO,
    output logic             WRAP
);

    localparam logic [WIDTH-1:0] RST_BIN  = RESET_VALUE[WIDTH-1:0];
    localparam logic [WIDTH-1:0] RST_GRAY = WIDTH'(bin2gray(32'(RST_BIN)));

    logic [WIDTH-1:0] r_gray;
    logic [WIDTH-1:0] r_bin;
    logic             r_par;
    logic             r_tc_max;
    logic             r_tc_zero;
    logic             r_wrap;

    logic [WIDTH-1:0] w_next;
    logic             w_at_limit;
    logic [WIDTH-1:0] w_gray_d;
    logic [WIDTH-1:0] w_bin_d;
    logic             w_par_d;
    logic             w_wrap_d;
    logic             w_step;

    gray_ud_next #(
        .WIDTH(WIDTH)
    ) u_next (
        .i_gray     (r_gray),
        .i_parity   (r_par),
        .i_dir      (UP_N_DN),
        .o_next     (w_next),
        .o_at_limit (w_at_limit)
    );

    always_comb begin
        w_step   = CE && !(SATURATE && w_at_limit);
        w_gray_d = r_gray;
        w_par_d  = r_par;
        w_wrap_d = 1'b0;
        w_bin_d  = r_bin;
        if (LOAD) begin
            w_gray_d = WIDTH'(bin2gray(32'(LOAD_VALUE)));
            w_par_d  = LOAD_VALUE[0];
            w_bin_d  = LOAD_VALUE;
        end else if (w_step) begin
            w_gray_d = w_next;
            w_par_d  = ~r_par;
            w_wrap_d = w_at_limit;
            w_bin_d  = WIDTH'(gray2bin(32'(w_next)));
        end
    end

    // Flags are derived from the next-state binary so they align with Q.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_gray    <= RST_GRAY;
            r_bin     <= RST_BIN;
            r_par     <= ^RST_GRAY;
            r_tc_max  <= (RST_BIN == '1);
            r_tc_zero <= (RST_BIN == '0);
            r_wrap    <= 1'b0;
        end else begin
            r_gray    <= w_gray_d;
            r_bin     <= w_bin_d;
            r_par     <= w_par_d;
            r_tc_max  <= (w_bin_d == '1);
            r_tc_zero <= (w_bin_d == '0);
            r_wrap    <= w_wrap_d;
        end
    end

    assign Q       = r_gray;
    assign Q_BIN   = r_bin;
    assign TC_MAX  = r_tc_max;
    assign TC_ZERO = r_tc_zero;
    assign WRAP    = r_wrap;

endmodule

// File: tb/tb_gray_updown_counter.sv
// Bench for gray_updown_counter: three 4-bit instances (wrap, saturate,
// reset value 3) driven with shared stimulus against a binary reference model.
module tb_gray_updown_counter;

    logic       CLK = 1'b0;
    logic       rst [3];
    logic       CE, UP, LOAD;
    logic [3:0] LV;
    logic [3:0] q   [3];
    logic [3:0] qb  [3];
    logic       tmax  [3];
    logic       tzero [3];
    logic       wrp   [3];

    always #5 CLK = ~CLK;

    gray_updown_counter #(.WIDTH(4), .SATURATE(1'b0), .RESET_VALUE(32'd0)) dut0 (
        .CLK(CLK), .RST(rst[0]), .CE(CE), .UP_N_DN(UP), .LOAD(LOAD), .LOAD_VALUE(LV),
        .Q(q[0]), .Q_BIN(qb[0]), .TC_MAX(tmax[0]), .TC_ZERO(tzero[0]), .WRAP(wrp[0]));

    gray_updown_counter #(.WIDTH(4), .SATURATE(1'b1), .RESET_VALUE(32'd0)) dut1 (
        .CLK(CLK), .RST(rst[1]), .CE(CE), .UP_N_DN(UP), .LOAD(LOAD), .LOAD_VALUE(LV),
        .Q(q[1]), .Q_BIN(qb[1]), .TC_MAX(tmax[1]), .TC_ZERO(tzero[1]), .WRAP(wrp[1]));

    gray_updown_counter #(.WIDTH(4), .SATURATE(1'b0), .RESET_VALUE(32'd3)) dut2 (
        .CLK(CLK), .RST(rst[2]), .CE(CE), .UP_N_DN(UP), .LOAD(LOAD), .LOAD_VALUE(LV),
        .Q(q[2]), .Q_BIN(qb[2]), .TC_MAX(tmax[2]), .TC_ZERO(tzero[2]), .WRAP(wrp[2]));

    typedef struct {
        logic       ld;
        logic [3:0] lv;
        logic       ce;
        logic       up;
        logic [3:0] q;
        logic [3:0] qb;
        logic       tmax;
        logic       tzero;
        logic       wrap;
    } vec_t;

    typedef struct {
        int         idx;
        logic [3:0] q;
        logic [3:0] qb;
        logic       tmax;
        logic       tzero;
        logic       wrap;
        int         ham;
        logic [3:0] pq;
    } exp_t;

    vec_t       vecs [$];
    exp_t       sbq  [$];
    logic [3:0] m_bin  [3];
    logic       m_wrap [3];
    logic [3:0] gseq   [16];
    int         n_chk  = 0;
    int         n_pass = 0;

    task automatic chk(input string name, input int idx, input logic [3:0] act, input logic [3:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s dut%0d: got %0h expected %0h at %0t", name, idx, act, exp, $time);
    endtask

    function automatic vec_t mkvec(input logic ld, input logic [3:0] lv, input logic ce, input logic up,
                                   input logic [3:0] eq, input logic [3:0] eqb, input logic etm,
                                   input logic etz, input logic ew);
        vec_t v;
        v.ld = ld; v.lv = lv; v.ce = ce; v.up = up;
        v.q = eq; v.qb = eqb; v.tmax = etm; v.tzero = etz; v.wrap = ew;
        return v;
    endfunction

    function automatic void mstep(input int i, input logic ld, input logic [3:0] lv,
                                  input logic ce, input logic up);
        m_wrap[i] = 1'b0;
        if (ld) begin
            m_bin[i] = lv;
        end else if (ce) begin
            if (up) begin
                if (m_bin[i] != 4'hF) m_bin[i] = m_bin[i] + 4'd1;
                else if (i != 1) begin m_bin[i] = 4'h0; m_wrap[i] = 1'b1; end
            end else begin
                if (m_bin[i] != 4'h0) m_bin[i] = m_bin[i] - 4'd1;
                else if (i != 1) begin m_bin[i] = 4'hF; m_wrap[i] = 1'b1; end
            end
        end
    endfunction

    task automatic step(input logic ld, input logic [3:0] lv, input logic ce, input logic up);
        logic [3:0] pq [3];
        logic [3:0] ob;
        exp_t       e;
        for (int i = 0; i < 3; i++) pq[i] = q[i];
        LOAD = ld; LV = lv; CE = ce; UP = up;
        @(posedge CLK);
        for (int i = 0; i < 3; i++) begin
            ob = m_bin[i];
            mstep(i, ld, lv, ce, up);
            e.idx   = i;
            e.qb    = m_bin[i];
            e.q     = m_bin[i] ^ (m_bin[i] >> 1);
            e.tmax  = (m_bin[i] == 4'hF);
            e.tzero = (m_bin[i] == 4'h0);
            e.wrap  = m_wrap[i];
            e.ham   = ld ? -1 : ((ob != m_bin[i]) ? 1 : 0);
            e.pq    = pq[i];
            sbq.push_back(e);
        end
        @(negedge CLK);
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk("q",     e.idx, q[e.idx],         e.q);
            chk("q_bin", e.idx, qb[e.idx],        e.qb);
            chk("tc_max",  e.idx, 4'(tmax[e.idx]),  4'(e.tmax));
            chk("tc_zero", e.idx, 4'(tzero[e.idx]), 4'(e.tzero));
            chk("wrap",  e.idx, 4'(wrp[e.idx]),   4'(e.wrap));
            if (e.ham >= 0)
                chk("hamming", e.idx, 4'($countones(q[e.idx] ^ e.pq)), 4'(e.ham));
        end
        LOAD = 1'b0; CE = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vec_t v;
        for (int i = 0; i < 3; i++) rst[i] = 1'b1;
        CE = 1'b0; UP = 1'b1; LOAD = 1'b0; LV = 4'h0;
        #3;
        chk("rst_q",     0, q[0],  4'h0);
        chk("rst_qbin",  0, qb[0], 4'h0);
        chk("rst_tzero", 0, 4'(tzero[0]), 4'h1);
        chk("rst_tmax",  0, 4'(tmax[0]),  4'h0);
        chk("rst_wrap",  0, 4'(wrp[0]),   4'h0);
        chk("rst_q",     2, q[2],  4'h2);
        chk("rst_qbin",  2, qb[2], 4'h3);
        chk("rst_tzero", 2, 4'(tzero[2]), 4'h0);
        @(negedge CLK);
        for (int i = 0; i < 3; i++) begin rst[i] = 1'b0; m_wrap[i] = 1'b0; end
        m_bin[0] = 4'h0; m_bin[1] = 4'h0; m_bin[2] = 4'h3;
        step(1'b0, 4'h0, 1'b0, 1'b1);

        gseq = '{4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC,
                 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0};
        for (int i = 0; i < 16; i++)
            vecs.push_back(mkvec(1'b0, 4'h0, 1'b1, 1'b1, gseq[i], 4'(i + 1),
                                 (i == 14), (i == 15), (i == 15)));
        vecs.push_back(mkvec(1'b0, 4'h0, 1'b1, 1'b0, 4'h8, 4'hF, 1'b1, 1'b0, 1'b1));
        vecs.push_back(mkvec(1'b0, 4'h0, 1'b0, 1'b0, 4'h8, 4'hF, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mkvec(1'b1, 4'h5, 1'b1, 1'b0, 4'h7, 4'h5, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mkvec(1'b0, 4'h0, 1'b1, 1'b0, 4'h6, 4'h4, 1'b0, 1'b0, 1'b0));
        foreach (vecs[k]) begin
            v = vecs[k];
            step(v.ld, v.lv, v.ce, v.up);
            chk("tbl_q",     0, q[0],  v.q);
            chk("tbl_qbin",  0, qb[0], v.qb);
            chk("tbl_tmax",  0, 4'(tmax[0]),  4'(v.tmax));
            chk("tbl_tzero", 0, 4'(tzero[0]), 4'(v.tzero));
            chk("tbl_wrap",  0, 4'(wrp[0]),   4'(v.wrap));
        end

        // Saturating instance pinned at max, then released downward.
        step(1'b1, 4'h0, 1'b0, 1'b1);
        for (int i = 0; i < 15; i++) step(1'b0, 4'h0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 4'h0, 1'b1, 1'b1);
            chk("sat_hold_q",    1, q[1], 4'h8);
            chk("sat_hold_wrap", 1, 4'(wrp[1]), 4'h0);
        end
        step(1'b0, 4'h0, 1'b1, 1'b0);
        chk("sat_dn_q",    1, q[1],  4'h9);
        chk("sat_dn_qbin", 1, qb[1], 4'hE);

        // Saturating instance at zero going down.
        step(1'b1, 4'h0, 1'b0, 1'b0);
        step(1'b0, 4'h0, 1'b1, 1'b0);
        chk("sat_zero_q",    1, q[1], 4'h0);
        chk("sat_zero_wrap", 1, 4'(wrp[1]), 4'h0);

        // Asynchronous reset between edges on the reset-value-3 instance.
        step(1'b1, 4'h0, 1'b0, 1'b1);
        step(1'b0, 4'h0, 1'b1, 1'b1);
        step(1'b0, 4'h0, 1'b1, 1'b1);
        #2 rst[2] = 1'b1;
        #1;
        chk("arst_q",    2, q[2],  4'h2);
        chk("arst_qbin", 2, qb[2], 4'h3);
        m_bin[2] = 4'h3; m_wrap[2] = 1'b0;
        #1 rst[2] = 1'b0;
        step(1'b0, 4'h0, 1'b1, 1'b1);
        chk("arst_resume_qbin", 2, qb[2], 4'h4);
        chk("arst_resume_q",    2, q[2],  4'h6);
        step(1'b0, 4'h0, 1'b1, 1'b1);
        chk("arst_resume2_qbin", 2, qb[2], 4'h5);

        // Direction changes with no dead cycle, then mixed random traffic.
        step(1'b0, 4'h0, 1'b1, 1'b0);
        step(1'b0, 4'h0, 1'b1, 1'b1);
        step(1'b0, 4'h0, 1'b1, 1'b0);
        step(1'b0, 4'h0, 1'b1, 1'b0);
        for (int i = 0; i < 60; i++)
            step(($urandom_range(0, 7) == 0), 4'($urandom_range(0, 15)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
